// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } wb_state_e;

  localparam logic       RESULT_ALU = 1'b0;
  localparam logic       RESULT_MEM = 1'b1;
  localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/wb_sequencer_if.sv
// Decoder/ALU, data-memory read and register-file write signals of the writeback sequencer.
interface wb_sequencer_if #(
  parameter int XLEN = 32
);
  logic            InstrValid;
  logic            IsLoad;
  logic            RegWriteIn;
  logic [4:0]      RdIn;
  logic [XLEN-1:0] ALUResult;
  logic            MemRdReady;
  logic            MemRdValid;
  logic [XLEN-1:0] ReadData;
  logic            MemReq;
  logic            ResultSrc;
  logic [XLEN-1:0] Result;
  logic            RegWrite;
  logic [4:0]      Rd;
  logic            Stall;
  logic            LoadErr;

  modport master (
    output InstrValid, IsLoad, RegWriteIn, RdIn, ALUResult,
    output MemRdReady, MemRdValid, ReadData,
    input  MemReq, ResultSrc, Result, RegWrite, Rd, Stall, LoadErr
  );

  modport slave (
    input  InstrValid, IsLoad, RegWriteIn, RdIn, ALUResult,
    input  MemRdReady, MemRdValid, ReadData,
    output MemReq, ResultSrc, Result, RegWrite, Rd, Stall, LoadErr
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Cycle counter for an outstanding load; expired_o is high in the LIMIT-th counted cycle.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, saturate at the last counted cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);
endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: shares the register-file write port between ALU results and loads.
// Optional load timeout enabled with `define WB_LOAD_TIMEOUT_EN.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  wb_sequencer_if.slave  bus
);
  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_e       state_q, state_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;

  logic            start_load_s;
  logic            timeout_s;
  logic            load_err_s;

  logic            mem_req_s;
  logic            result_src_s;
  logic [XLEN-1:0] result_s;
  logic            reg_write_s;
  logic [4:0]      rd_s;
  logic            stall_s;

  assign start_load_s = (state_q == ST_IDLE) && bus.InstrValid && bus.IsLoad;

`ifdef WB_LOAD_TIMEOUT_EN
  logic in_flight_s;
  logic expired_s;
  logic load_err_q;

  assign in_flight_s = (state_q == ST_REQ) || (state_q == ST_WAIT);

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_load_s),
    .enable_i  (in_flight_s),
    .expired_o (expired_s)
  );

  // Data returning in the expiry cycle still completes the load.
  assign timeout_s = expired_s && !((state_q == ST_WAIT) && bus.MemRdValid);

  // One-cycle error pulse, shown in the IDLE cycle after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= timeout_s;
    end
  end

  assign load_err_s = load_err_q;
`else
  assign timeout_s  = 1'b0;
  assign load_err_s = 1'b0;
`endif

  // State and load-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_data_q <= '0;
      rd_q        <= REG_ZERO;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Next-state logic; MemRdValid is only accepted in WAIT.
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    case (state_q)
      ST_IDLE: begin
        if (start_load_s) begin
          rd_d        = bus.RdIn;
          reg_write_d = bus.RegWriteIn;
          state_d     = bus.MemRdReady ? ST_WAIT : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
        end else if (bus.MemRdReady) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.MemRdValid) begin
          load_data_d = bus.ReadData;
          state_d     = ST_WB;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    mem_req_s    = 1'b0;
    result_src_s = RESULT_ALU;
    result_s     = '0;
    reg_write_s  = 1'b0;
    rd_s         = REG_ZERO;
    stall_s      = 1'b0;
    if (rst) begin
      mem_req_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.InstrValid && bus.IsLoad) begin
            mem_req_s = 1'b1;
            stall_s   = 1'b1;
            result_s  = bus.ALUResult;
          end else if (bus.InstrValid) begin
            result_s    = bus.ALUResult;
            rd_s        = bus.RdIn;
            reg_write_s = bus.RegWriteIn && (bus.RdIn != REG_ZERO);
          end else begin
            stall_s = 1'b0;
          end
        end
        ST_REQ: begin
          mem_req_s = 1'b1;
          stall_s   = 1'b1;
        end
        ST_WAIT: begin
          stall_s = 1'b1;
        end
        ST_WB: begin
          result_src_s = RESULT_MEM;
          result_s     = load_data_q;
          rd_s         = rd_q;
          reg_write_s  = reg_write_q && (rd_q != REG_ZERO);
        end
        default: begin
          stall_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.MemReq    = mem_req_s;
  assign bus.ResultSrc = result_src_s;
  assign bus.Result    = result_s;
  assign bus.RegWrite  = reg_write_s;
  assign bus.Rd        = rd_s;
  assign bus.Stall     = stall_s;
  assign bus.LoadErr   = rst ? 1'b0 : load_err_s;
endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
Writeback controller sharing the register-file write port between the single-cycle ALU path and a variable-latency data-memory read path. It drives the result-select line, RegWrite and the memory read request. It stalls the PC/fetch while a load is outstanding, then writes the returned data back. It sits between the decoder/ALU and the register file.

Parameters:
XLEN, 32, datapath width of ALUResult/ReadData/Result
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before abort (used only with optional feature); counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
InstrValid  input  1  decoded instruction present this cycle
IsLoad  input  1  instruction's result comes from data memory
RegWriteIn  input  1  decoder's register write enable
RdIn  input  5  destination register index
ALUResult  input  XLEN  ALU output (also the load address, presented by the core)
MemRdReady  input  1  memory accepts the read request this cycle
MemRdValid  input  1  ReadData valid this cycle
ReadData  input  XLEN  memory read data
MemReq  output  1  read request to data memory
ResultSrc  output  1  0 = ALU result, 1 = load data
Result  output  XLEN  writeback data to register file
RegWrite  output  1  register-file write enable
Rd  output  5  register-file write index
Stall  output  1  hold PC and instruction (load in flight)
LoadErr  output  1  one-cycle pulse on load timeout (0 without feature)

Behaviour:
- Reset: state=IDLE; LoadDataQ, RdQ, RegWriteQ, timeout counter cleared. While rst=1 all outputs are 0, including combinational ones. Reset mid-load abandons the load with no writeback; a late MemRdValid is ignored.
- RegWrite is never asserted when the selected Rd==0.
- IDLE:
  - InstrValid & !IsLoad: same-cycle pass-through. ResultSrc=0, Result=ALUResult, Rd=RdIn, RegWrite=RegWriteIn, Stall=0, MemReq=0.
  - InstrValid & IsLoad: MemReq=1, Stall=1, RegWrite=0. Latch RdIn/RegWriteIn. If MemRdReady, go to WAIT; else go to REQ.
  - !InstrValid: all outputs 0.
- REQ: MemReq=1, Stall=1. On MemRdReady, go to WAIT.
- WAIT: MemReq=0, Stall=1. On MemRdValid, LoadDataQ<=ReadData and go to WB. MemRdValid is not accepted in the same cycle the request is accepted (minimum latency 1).
- WB: ResultSrc=1, Result=LoadDataQ, Rd=RdQ, RegWrite=RegWriteQ&(RdQ!=0), Stall=0. Next state is IDLE unconditionally. Load-to-writeback minimum is 3 cycles (IDLE, WAIT, WB).
- MemRdValid in IDLE/REQ/WB is ignored. InstrValid/IsLoad are ignored outside IDLE (the instruction is held by Stall).
- Result is always driven with the mux value; it is don't-care when RegWrite=0.

Optional Feature:
WB_LOAD_TIMEOUT_EN:
- With the macro: counter clears on IDLE->REQ/WAIT and increments each cycle in REQ/WAIT. When the count reaches TIMEOUT_CYCLES without completion, go to IDLE, pulse LoadErr=1 for one cycle, drop Stall, suppress writeback, and deassert MemReq.
- Without the macro: no counter; the block waits indefinitely; LoadErr tied to 0.

Decomposition:
- Package wb_pkg: state enum (IDLE, REQ, WAIT, WB; 2 bits), RESULT_ALU=0 / RESULT_MEM=1 constants, REG_ZERO=5'd0.
- One natural sub-module: wb_timeout_counter (clear/enable/expired). It is instantiated only under WB_LOAD_TIMEOUT_EN.

Test Plan:
- ALU op: InstrValid=1, IsLoad=0, RdIn=5, ALUResult=32'h1234 -> same cycle RegWrite=1, Rd=5, Result=32'h1234, ResultSrc=0, Stall=0.
- Load, ready immediately, data after 4 cycles: RdIn=7, ReadData=32'hCAFEF00D -> Stall=1 for 5 cycles; WB cycle shows ResultSrc=1, Result=32'hCAFEF00D, Rd=7, RegWrite=1; next cycle IDLE.
- Load with MemRdReady low for 3 cycles -> MemReq held 4 cycles, no RegWrite before WB; spurious MemRdValid during REQ is ignored.
- Load to x0 (RdIn=0) -> full sequence runs, RegWrite stays 0 throughout.
- rst=1 in WAIT -> next cycle all outputs 0, state IDLE; MemRdValid arriving afterward causes no write.
- With WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, MemRdValid never asserted -> after 8 cycles LoadErr pulses once, Stall drops, RegWrite stays 0.
